// File: rtl/booth_mul_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiply controller.
// FSM state encoding, Booth recode operations and the default operand width.
package booth_mul_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // Radix-2 recode of the pair {Q[0], Q_m1}.
    function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
        booth_op_e op;
        unique case ({q0, qm1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/adder_32_bit.sv
// 32-bit ripple-style adder with carry in and carry out.
// Shared by the Booth controller for add, subtract and pass-through.
module adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/booth_mul_ctrl.sv
// Multi-cycle signed multiplier controller using radix-2 Booth recoding.
// One Booth step per cycle on a single shared adder; product held in prod_hi/prod_lo.
module booth_mul_ctrl
    import booth_mul_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    state_e           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_m1;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] count;

    booth_op_e        op;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout_unused;
    logic             ovf;
    logic             sgn;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] q_next;

    assign op = booth_decode(q_reg[0], q_m1);

    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        unique case (op)
            BOOTH_ADD: begin
                add_b   = m_reg;
                add_cin = 1'b0;
            end
            BOOTH_SUB: begin
                add_b   = ~m_reg;
                add_cin = 1'b1;
            end
            default: begin
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    adder_32_bit u_adder (
        .a    (a_reg),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout_unused)
    );

    // Recover the true sign of the partial sum; needed when M = -2^(WIDTH-1).
    assign ovf    = (a_reg[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != a_reg[WIDTH-1]);
    assign sgn    = add_sum[WIDTH-1] ^ ovf;
    assign a_next = {sgn, add_sum[WIDTH-1:1]};
    assign q_next = {add_sum[0], q_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            prod_hi <= '0;
            prod_lo <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            q_m1    <= 1'b0;
            m_reg   <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg <= '0;
                        q_reg <= multiplier;
                        q_m1  <= 1'b0;
                        m_reg <= multiplicand;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_m1  <= q_reg[0];
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        prod_hi <= a_next;
                        prod_lo <= q_next;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: cycle-level reference model plus directed vectors.
// The model only knows "busy for 33 cycles after an accepted start, product = M*Q".
module tb_booth_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] mc = '0;
    logic [31:0] mq = '0;
    logic        busy;
    logic        done;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mul_ctrl #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (mc),
        .multiplier   (mq),
        .busy         (busy),
        .done         (done),
        .prod_hi      (prod_hi),
        .prod_lo      (prod_lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        logic signed [63:0] ms;
        logic signed [63:0] qs;
        ms = $signed(m);
        qs = $signed(q);
        return ms * qs;
    endfunction

    // Reference model: an accepted start makes the unit busy for 33 cycles, the last of
    // which carries done and the new product; otherwise the product simply holds.
    int          rem = 0;
    logic [63:0] pend = '0;
    logic [63:0] exp_prod = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            rem      = 0;
            exp_prod = '0;
        end else if (rem == 0) begin
            if (start) begin
                rem  = 33;
                pend = ref_mul(mc, mq);
            end
        end else begin
            rem--;
            if (rem == 1) exp_prod = pend;
        end
    end

    int cyc_n     = 0;
    int last_done = -1;
    bit b2b       = 1'b0;

    always @(negedge clk) begin
        cyc_n++;
        chk("busy", 64'(busy), 64'(rem > 0));
        chk("done", 64'(done), 64'(rem == 1));
        chk("prod", {prod_hi, prod_lo}, exp_prod);
        if (done) begin
            if (b2b && last_done >= 0) chk("done_gap", 64'(cyc_n - last_done), 64'd34);
            last_done = cyc_n;
        end
    end

    // Launch one multiply; optionally poke start (2 x 2) at two cycles, or pull reset at
    // abort_at. With hold=0 it returns in the done cycle, otherwise after 40 cycles.
    task automatic run(input logic [31:0] m, input logic [31:0] q, input int poke_a,
                       input int poke_b, input int abort_at, input bit hold,
                       output int lat, output int ndone);
        @(negedge clk);
        start = 1'b1;
        mc    = m;
        mq    = q;
        lat   = 0;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            mc    = $urandom;
            mq    = $urandom;
            rst_n = 1'b1;
            if (done) begin
                ndone++;
                if (lat == 0) lat = c;
                if (!hold) break;
            end
            if (c == poke_a || c == poke_b) begin
                start = 1'b1;
                mc    = 32'd2;
                mq    = 32'd2;
            end
            if (c == abort_at) rst_n = 1'b0;
        end
        if (!hold && lat == 0) chk("done_timeout", 64'(lat), 64'd33);
    endtask

    int lat;
    int nd;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", {prod_hi, prod_lo}, 64'd0);
        rst_n = 1'b1;

        run(32'd3, 32'd5, 0, 0, 0, 1'b0, lat, nd);
        chk("lat_3x5", 64'(lat), 64'd33);
        chk("p_3x5", {prod_hi, prod_lo}, 64'h00000000_0000000F);

        run(-32'sd16, -32'sd8, 0, 0, 0, 1'b0, lat, nd);
        chk("p_m16xm8", {prod_hi, prod_lo}, 64'h00000000_00000080);
        run(32'd16, -32'sd8, 0, 0, 0, 1'b0, lat, nd);
        chk("p_16xm8", {prod_hi, prod_lo}, 64'hFFFFFFFF_FFFFFF80);

        run(32'h80000000, 32'h80000000, 0, 0, 0, 1'b0, lat, nd);
        chk("p_minxmin", {prod_hi, prod_lo}, 64'h40000000_00000000);
        run(32'h7FFFFFFF, 32'h80000000, 0, 0, 0, 1'b0, lat, nd);
        chk("p_maxxmin", {prod_hi, prod_lo}, 64'hC0000000_80000000);

        run(32'd7, 32'd9, 10, 33, 0, 1'b1, lat, nd);
        chk("ign_lat", 64'(lat), 64'd33);
        chk("ign_ndone", 64'(nd), 64'd1);
        chk("p_7x9", {prod_hi, prod_lo}, 64'h00000000_0000003F);

        run(32'd6, 32'd7, 0, 0, 15, 1'b1, lat, nd);
        chk("abort_ndone", 64'(nd), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_prod", {prod_hi, prod_lo}, 64'd0);
        run(32'd6, 32'd7, 0, 0, 0, 1'b0, lat, nd);
        chk("p_6x7", {prod_hi, prod_lo}, 64'h00000000_0000002A);
        chk("lat_6x7", 64'(lat), 64'd33);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] rm;
            logic [31:0] rq;
            rm = $urandom;
            rq = $urandom;
            if (i == 1) b2b = 1'b1;
            run(rm, rq, 0, 0, 0, 1'b0, lat, nd);
            chk("p_rand", {prod_hi, prod_lo}, ref_mul(rm, rq));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
